// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one 1-bit full adder cell is reused for WIDTH cycles,
// LSB first, with the carry kept in a flop between bits.

module fulladder1 (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout_out;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_s_next;

  fulladder1 u_fa (
    .sum  (w_fa_sum),
    .cout (w_fa_cout),
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry)
  );

  // New sum bit enters at the MSB so that after WIDTH steps the LSB-first
  // results line up in natural order.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_s_next = w_fa_sum;
    end else begin : g_wn
      assign w_s_next = {w_fa_sum, r_s_sh[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == LAST_CNT);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Start arriving in RUN or DONE never reaches this block: w_accept is only
  // raised in IDLE, so captured operands cannot be disturbed mid-operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_s_sh     <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_sum_out  <= '0;
      r_cout_out <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a_in;
      r_b_sh  <= b_in;
      r_carry <= cin_in;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_s_sh  <= w_s_next;
      r_carry <= w_fa_cout;
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum_out  <= w_s_next;
        r_cout_out <= w_fa_cout;
      end
    end
  end

  assign busy     = w_busy;
  assign done     = w_done;
  assign sum_out  = r_sum_out;
  assign cout_out = r_cout_out;

endmodule
